// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared types and pure functions for the iterative AES core:
//   - key-size derived constants (NK, NR, NW) as functions of KEY_BITS
//   - the core FSM state enum
//   - byte/word/block typedefs (FIPS-197 order: byte 0 is the MSB byte)
//   - GF(2^8) xtime, (inverse) MixColumns on one column and on a block
//   - ShiftRows / InvShiftRows byte permutations
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        ROUND,
        DONE
    } aes_state_t;

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic int nw_of(input int key_bits);
        return 4 * (key_bits / 32 + 7);
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t mix_col(input word_t w);
        byte_t a  [4];
        byte_t m2 [4];
        byte_t m3 [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = w[31-8*i -: 8];
            m2[i] = xtime(a[i]);
            m3[i] = m2[i] ^ a[i];
        end
        return {m2[0] ^ m3[1] ^ a[2]  ^ a[3],
                a[0]  ^ m2[1] ^ m3[2] ^ a[3],
                a[0]  ^ a[1]  ^ m2[2] ^ m3[3],
                m3[0] ^ a[1]  ^ a[2]  ^ m2[3]};
    endfunction

    function automatic word_t inv_mix_col(input word_t w);
        byte_t m9 [4];
        byte_t mb [4];
        byte_t md [4];
        byte_t me [4];
        byte_t a, x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a     = w[31-8*i -: 8];
            x2    = xtime(a);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic block_t mix_columns(input block_t s);
        block_t t;
        for (int c = 0; c < 4; c++) begin
            t[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        end
        return t;
    endfunction

    function automatic block_t inv_mix_columns(input block_t s);
        block_t t;
        for (int c = 0; c < 4; c++) begin
            t[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        end
        return t;
    endfunction

    // Byte k of the block sits at row k%4, column k/4. Row r rotates left by r.
    function automatic block_t shift_rows(input block_t s);
        block_t t;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return t;
    endfunction

    function automatic block_t inv_shift_rows(input block_t s);
        block_t t;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/aes_sbox_dual.sv
// -----------------------------------------------------------------------------
// aes_sbox_dual
// Combinational AES S-box, forward or inverse selected by inv.
// Computed as GF(2^8) inversion plus the affine map rather than a lookup
// table; both directions share the one inverter.
// Ports:
//   inv : 1 = inverse S-box, 0 = forward S-box
//   a   : input byte
//   y   : substituted byte
// -----------------------------------------------------------------------------
module aes_sbox_dual
    import aes_pkg::*;
(
    input  logic       inv,
    input  logic [7:0] a,
    output logic [7:0] y
);

    function automatic byte_t gf_mul(input byte_t p, input byte_t q);
        byte_t acc = 8'h00;
        byte_t x   = p;
        for (int i = 0; i < 8; i++) begin
            if (q[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
    function automatic byte_t gf_inv(input byte_t v);
        byte_t       acc = 8'h01;
        byte_t       sq  = v;
        logic  [7:0] e   = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) acc = gf_mul(acc, sq);
            sq = gf_mul(sq, sq);
        end
        return acc;
    endfunction

    function automatic byte_t affine_fwd(input byte_t b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic byte_t affine_inv(input byte_t b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    byte_t pre_map;
    byte_t inv_val;

    always_comb begin
        pre_map = inv ? affine_inv(a) : a;
        inv_val = gf_inv(pre_map);
        y       = inv ? inv_val : affine_fwd(inv_val);
    end

endmodule

// File: rtl/aes_iter_core.sv
// -----------------------------------------------------------------------------
// aes_iter_core
// Iterative AES-128/192/256 core, one round per clock. The key schedule is
// expanded once per key_load into a register file of NW words (one word per
// cycle) and reused for any number of encrypt/decrypt blocks.
// Ports:
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   key_load, key     : key capture strobe and cipher key (MSB = byte 0)
//   key_ready         : a complete round-key set is held
//   load, enc, din    : block start strobe, 1 = encrypt / 0 = decrypt, input
//   busy              : expansion or block in progress
//   ready, dout       : one-cycle result strobe and held result
// -----------------------------------------------------------------------------
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                key_load,
    input  logic [KEY_BITS-1:0] key,
    output logic                key_ready,
    input  logic                load,
    input  logic                enc,
    input  logic [127:0]        din,
    output logic                busy,
    output logic                ready,
    output logic [127:0]        dout
);

    localparam int NK = nk_of(KEY_BITS);
    localparam int NR = nr_of(KEY_BITS);
    localparam int NW = nw_of(KEY_BITS);
    localparam int IW = $clog2(NW);
    localparam int RW = $clog2(NR + 1);
    localparam int KW = $clog2(NK);

    aes_state_t    state_reg, state_next;

    word_t         rk_reg [NW];
    block_t        rk_blk [NR+1];

    logic [IW-1:0] widx_reg;       // index of the word being produced
    logic [KW-1:0] kpos_reg;       // widx_reg mod NK, tracked incrementally
    byte_t         rcon_reg;
    logic          key_ready_reg;
    logic          enc_reg;
    logic          ready_reg;
    logic [RW-1:0] rnd_reg;
    block_t        blk_reg;
    block_t        dout_reg;

    logic          start_expand, expand_step, start_block, round_step, finish;
    logic          last_word, last_round;

    assign last_word  = (int'(widx_reg) == NW - 1);
    assign last_round = (int'(rnd_reg) == NR);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // key_load overrides everything, including a block in flight.
    always_comb begin
        state_next   = state_reg;
        start_expand = 1'b0;
        expand_step  = 1'b0;
        start_block  = 1'b0;
        round_step   = 1'b0;
        finish       = 1'b0;
        if (key_load) begin
            state_next   = EXPAND;
            start_expand = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load && key_ready_reg) begin
                        state_next  = ROUND;
                        start_block = 1'b1;
                    end
                end
                EXPAND: begin
                    expand_step = 1'b1;
                    if (last_word) state_next = IDLE;
                end
                ROUND: begin
                    round_step = 1'b1;
                    if (last_round) state_next = DONE;
                end
                DONE: begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------ key expansion
    logic [IW-1:0] prev_idx, back_idx;
    word_t         prev_w, back_w, sub_in, sub_out, new_w;

    assign prev_idx = widx_reg - IW'(1);
    assign back_idx = widx_reg - IW'(NK);
    assign prev_w   = rk_reg[prev_idx];
    assign back_w   = rk_reg[back_idx];
    assign sub_in   = (kpos_reg == '0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    for (genvar gi = 0; gi < 4; gi++) begin : g_key_sbox
        aes_sbox_dual u_key_sbox (
            .inv (1'b0),
            .a   (sub_in[31-8*gi -: 8]),
            .y   (sub_out[31-8*gi -: 8])
        );
    end

    always_comb begin
        if (kpos_reg == '0)
            new_w = back_w ^ sub_out ^ {rcon_reg, 24'h000000};
        else if ((NK == 8) && (int'(kpos_reg) == 4))
            new_w = back_w ^ sub_out;
        else
            new_w = back_w ^ prev_w;
    end

    // Round-key words carry no reset: key_ready gates every use of them.
    always_ff @(posedge clk) begin
        if (start_expand) begin
            for (int j = 0; j < NK; j++) begin
                rk_reg[j] <= key[KEY_BITS-1-32*j -: 32];
            end
        end else if (expand_step) begin
            rk_reg[widx_reg] <= new_w;
        end
    end

    for (genvar gi = 0; gi <= NR; gi++) begin : g_rk
        assign rk_blk[gi] = {rk_reg[4*gi], rk_reg[4*gi+1], rk_reg[4*gi+2], rk_reg[4*gi+3]};
    end

    // ----------------------------------------------------- round datapath
    // SubBytes commutes with ShiftRows, so encryption substitutes first and
    // permutes after; decryption permutes first. This lets both directions
    // share the same 16 S-boxes.
    block_t        sbox_in, sbox_out, enc_lin, dec_add, round_out;
    logic [RW-1:0] dec_ridx;

    assign sbox_in  = enc_reg ? blk_reg : inv_shift_rows(blk_reg);
    assign dec_ridx = RW'(NR) - rnd_reg;

    for (genvar gi = 0; gi < 16; gi++) begin : g_round_sbox
        aes_sbox_dual u_round_sbox (
            .inv (~enc_reg),
            .a   (sbox_in[127-8*gi -: 8]),
            .y   (sbox_out[127-8*gi -: 8])
        );
    end

    always_comb begin
        enc_lin = shift_rows(sbox_out);
        dec_add = sbox_out ^ rk_blk[dec_ridx];
        if (enc_reg)
            round_out = (last_round ? enc_lin : mix_columns(enc_lin)) ^ rk_blk[rnd_reg];
        else
            round_out = last_round ? dec_add : inv_mix_columns(dec_add);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_ready_reg <= 1'b0;
            widx_reg      <= '0;
            kpos_reg      <= '0;
            rcon_reg      <= 8'h00;
            enc_reg       <= 1'b0;
            rnd_reg       <= '0;
            blk_reg       <= '0;
            dout_reg      <= '0;
            ready_reg     <= 1'b0;
        end else begin
            ready_reg <= finish;
            if (start_expand) begin
                key_ready_reg <= 1'b0;
                widx_reg      <= IW'(NK);
                kpos_reg      <= '0;
                rcon_reg      <= 8'h01;
            end
            if (expand_step) begin
                widx_reg <= widx_reg + IW'(1);
                kpos_reg <= (int'(kpos_reg) == NK - 1) ? '0 : kpos_reg + KW'(1);
                if (kpos_reg == '0) rcon_reg <= xtime(rcon_reg);
                if (last_word) key_ready_reg <= 1'b1;
            end
            if (start_block) begin
                enc_reg <= enc;
                blk_reg <= din ^ (enc ? rk_blk[0] : rk_blk[NR]);
                rnd_reg <= RW'(1);
            end
            if (round_step) begin
                blk_reg <= round_out;
                if (!last_round) rnd_reg <= rnd_reg + RW'(1);
            end
            // dout and ready move together so an aborted block never
            // disturbs the previously presented result.
            if (finish) dout_reg <= blk_reg;
        end
    end

    assign key_ready = key_ready_reg;
    assign busy      = (state_reg != IDLE);
    assign ready     = ready_reg;
    assign dout      = dout_reg;

endmodule
